// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the processor dmem port.
// Holds a single-port read-before-write RAM plus a small MMIO window:
//   FFFF_FFF0  COUNTER    free-running cycle counter (read / load)
//   FFFF_FFF1  FIFO_DATA  push data[7:0] into the output byte FIFO
//   FFFF_FFF2  STATUS     {ovf, full, empty, count}; write data[0]=1 clears ovf
// Optional feature macro: DMEM_COUNTER_EN builds the cycle counter. When it is
// undefined, COUNTER behaves like an unmapped address.
module dmem_responder #(
  parameter int unsigned RAM_DEPTH  = 4096,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int unsigned AW = $clog2(RAM_DEPTH);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [31:0] AddrCounter  = 32'hFFFF_FFF0;
  localparam logic [31:0] AddrFifoData = 32'hFFFF_FFF1;
  localparam logic [31:0] AddrStatus   = 32'hFFFF_FFF2;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic ram_sel;
  logic cnt_sel;
  logic fifo_sel;
  logic stat_sel;

  assign ram_sel  = (address_dmem[31:AW] == '0);
  assign cnt_sel  = (address_dmem == AddrCounter);
  assign fifo_sel = (address_dmem == AddrFifoData);
  assign stat_sel = (address_dmem == AddrStatus);

  // ---------------------------------------------------------------------------
  // RAM: contents survive reset; stores are suppressed in reset cycles
  // ---------------------------------------------------------------------------
  logic [31:0] ram_q [RAM_DEPTH];
  logic [31:0] ram_rdata;

  assign ram_rdata = ram_q[address_dmem[AW-1:0]];

  // Commit RAM stores; the registered read below sees the pre-store word.
  always_ff @(posedge clock) begin
    if (!reset && wren && ram_sel) begin
      ram_q[address_dmem[AW-1:0]] <= data;
    end
  end

  // ---------------------------------------------------------------------------
  // Cycle counter
  // ---------------------------------------------------------------------------
  logic [31:0] cnt_val;

`ifdef DMEM_COUNTER_EN
  logic [31:0] cnt_q, cnt_d;

  // A store to COUNTER takes priority over the increment.
  always_comb begin
    cnt_d = cnt_q + 32'd1;
    if (wren && cnt_sel) begin
      cnt_d = data;
    end
  end

  // Counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_val = cnt_q;
`else
  // No counter built: COUNTER reads as zero and stores fall on the floor.
  assign cnt_val = '0;
`endif

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic fifo_empty;
  logic fifo_full;
  logic push_req;
  logic push_ok;
  logic pop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign out_valid  = !fifo_empty;
  assign out_data   = fifo_mem_q[rd_ptr_q];

  assign pop      = out_valid && out_ready;
  assign push_req = wren && fifo_sel;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign push_ok  = push_req && (!fifo_full || pop);

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (push_req && !push_ok) begin
      ovf_d = 1'b1;
    end else if (wren && stat_sel && data[0]) begin
      ovf_d = 1'b0;
    end
  end

  // FIFO control registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; no reset needed since occupancy masks stale entries.
  always_ff @(posedge clock) begin
    if (!reset && push_ok) begin
      fifo_mem_q[wr_ptr_q] <= data[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Read-data path
  // ---------------------------------------------------------------------------
  logic [31:0] status_word;
  logic [31:0] q_dmem_d;
  logic [31:0] q_dmem_q;

  // Assemble STATUS from pre-edge state.
  always_comb begin
    status_word         = '0;
    status_word[CW-1:0] = count_q;
    status_word[CW]     = fifo_empty;
    status_word[CW+1]   = fifo_full;
    status_word[CW+2]   = ovf_q;
  end

  // Select the read value; FIFO_DATA and unmapped addresses read as zero.
  always_comb begin
    q_dmem_d = '0;
    if (ram_sel) begin
      q_dmem_d = ram_rdata;
    end else if (cnt_sel) begin
      q_dmem_d = cnt_val;
    end else if (stat_sel) begin
      q_dmem_d = status_word;
    end
  end

  // Registered read data, loaded every cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_dmem_q <= '0;
    end else begin
      q_dmem_q <= q_dmem_d;
    end
  end

  assign q_dmem = q_dmem_q;

endmodule
